// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select codes and FSM encoding for the forwarding/hazard unit
package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - single-source bypass priority select (EX/MEM over MEM/WB over regfile)
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    output logic [1:0]            sel
);

    // Youngest producer wins; x0 is hardwired zero so it is never bypassed.
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand bypass selects and load-use stall FSM; FWD_PERF_EN adds perf counters
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_addr,
    input  logic [REG_ADDR_W-1:0]         ex_rd_addr,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_rd_addr,
    input  logic                          mem_reg_write,
    input  logic [REG_ADDR_W-1:0]         wb_rd_addr,
    input  logic                          wb_reg_write,
    input  logic                          ext_hold,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall,
`ifdef FWD_PERF_EN
    output logic                          bubble,
    output logic [CNT_W-1:0]              perf_fwd_cnt,
    output logic [CNT_W-1:0]              perf_stall_cnt
`else
    output logic                          bubble
`endif
);

    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic [2:0] CNT_INIT    = 3'(LOAD_LAT - 1);

    if ((LOAD_LAT < 1) || (LOAD_LAT > 7) || (CNT_W < 1) || (NUM_SRC < 1)) begin : g_bad_param
        $error("fwd_hazard_unit: LOAD_LAT must be 1..7, CNT_W and NUM_SRC at least 1");
    end

    logic [NUM_SRC*2-1:0] sel_raw;
    logic                 src_hit;
    logic                 hz;
    logic                 stall_int;
    fsm_state_t           state;
    logic [2:0]           cnt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_sel (
            .ex_rs         (ex_rs_addr[g*REG_ADDR_W +: REG_ADDR_W]),
            .mem_rd_addr   (mem_rd_addr),
            .mem_reg_write (mem_reg_write),
            .wb_rd_addr    (wb_rd_addr),
            .wb_reg_write  (wb_reg_write),
            .sel           (sel_raw[g*2 +: 2])
        );
    end

    assign fwd_sel = arst_n ? sel_raw : '0;

    // Load-use hazard: the ID/EX load's rd is read by any live source of the IF/ID instruction.
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_hit = src_hit | (id_rs_used[i] && (id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd_addr));
        end
        hz = ex_mem_read && ex_reg_write && (ex_rd_addr != '0) && src_hit;
    end

    // Stall FSM: the first bubble is issued from IDLE, the remaining LOAD_LAT-1 from STALL; ext_hold freezes it.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!ext_hold) begin
            case (state)
                ST_IDLE: begin
                    if (hz && MULTI_CYCLE) begin
                        state <= ST_STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_STALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stall_int = arst_n && ((state == ST_STALL) || hz);
    assign stall     = stall_int;
    assign bubble    = stall_int;

`ifdef FWD_PERF_EN
    // Saturating event counters: forwarding only counts on cycles the pipeline actually advances.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            perf_fwd_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if ((|fwd_sel) && !ext_hold && (perf_fwd_cnt != '1)) begin
                perf_fwd_cnt <= perf_fwd_cnt + 1'b1;
            end
            if (stall_int && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    logic       clk;
    logic       arst_n;
    logic [9:0] id_rs_addr;
    logic [1:0] id_rs_used;
    logic [9:0] ex_rs_addr;
    logic [4:0] ex_rd_addr;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rd_addr;
    logic       mem_reg_write;
    logic [4:0] wb_rd_addr;
    logic       wb_reg_write;
    logic       ext_hold;

    logic [3:0] fwd_sel_1, fwd_sel_2, fwd_sel_3;
    logic       stall_1, stall_2, stall_3;
    logic       bubble_1, bubble_2, bubble_3;
`ifdef FWD_PERF_EN
    logic [1:0]  pf_1, ps_1;
    logic [31:0] pf_2, ps_2, pf_3, ps_3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(2)) u1 (
        .clk(clk), .arst_n(arst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .ext_hold(ext_hold),
        .fwd_sel(fwd_sel_1), .stall(stall_1),
`ifdef FWD_PERF_EN
        .bubble(bubble_1), .perf_fwd_cnt(pf_1), .perf_stall_cnt(ps_1)
`else
        .bubble(bubble_1)
`endif
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(32)) u2 (
        .clk(clk), .arst_n(arst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .ext_hold(ext_hold),
        .fwd_sel(fwd_sel_2), .stall(stall_2),
`ifdef FWD_PERF_EN
        .bubble(bubble_2), .perf_fwd_cnt(pf_2), .perf_stall_cnt(ps_2)
`else
        .bubble(bubble_2)
`endif
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(32)) u3 (
        .clk(clk), .arst_n(arst_n), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .ex_rs_addr(ex_rs_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .ext_hold(ext_hold),
        .fwd_sel(fwd_sel_3), .stall(stall_3),
`ifdef FWD_PERF_EN
        .bubble(bubble_3), .perf_fwd_cnt(pf_3), .perf_stall_cnt(ps_3)
`else
        .bubble(bubble_3)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_addr    = '0;
        id_rs_used    = '0;
        ex_rs_addr    = '0;
        ex_rd_addr    = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd_addr   = '0;
        mem_reg_write = 1'b0;
        wb_rd_addr    = '0;
        wb_reg_write  = 1'b0;
        ext_hold      = 1'b0;
    endtask

    // load writing x7, consumer reads x7 on src1
    task automatic set_hazard();
        ex_mem_read  = 1'b1;
        ex_reg_write = 1'b1;
        ex_rd_addr   = 5'd7;
        id_rs_addr   = {5'd7, 5'd3};
        id_rs_used   = 2'b10;
    endtask

    task automatic clear_hazard();
        ex_mem_read  = 1'b0;
        ex_reg_write = 1'b0;
        ex_rd_addr   = '0;
        id_rs_addr   = '0;
        id_rs_used   = '0;
    endtask

    int run_len;

    initial begin
        clear_inputs();
        arst_n = 1'b0;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; ex_rs_addr = {5'd0, 5'd5};
        set_hazard();
        tick();
        check_eq("rst_fwd_sel", 32'(fwd_sel_1), 32'h0);
        check_eq("rst_stall",   32'(stall_1),   32'h0);
        check_eq("rst_bubble3", 32'(bubble_3),  32'h0);
        clear_inputs();
        arst_n = 1'b1;
        tick();

        // forwarding vectors
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; wb_reg_write = 1'b1; wb_rd_addr = 5'd5;
        ex_rs_addr = {5'd9, 5'd5};
        #1 check_eq("fwd_mem_prio", 32'(fwd_sel_1), 32'h2);
        mem_reg_write = 1'b0;
        #1 check_eq("fwd_wb", 32'(fwd_sel_1), 32'h1);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd0; wb_reg_write = 1'b0; ex_rs_addr = {5'd9, 5'd0};
        #1 check_eq("fwd_x0_mem", 32'(fwd_sel_1), 32'h0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd_addr = 5'd0;
        #1 check_eq("fwd_x0_wb", 32'(fwd_sel_1), 32'h0);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; wb_rd_addr = 5'd9; ex_rs_addr = {5'd9, 5'd5};
        #1 check_eq("fwd_both_src", 32'(fwd_sel_1), 32'h6);
        mem_rd_addr = 5'b10101; wb_reg_write = 1'b0;
        #1 check_eq("fwd_full_width", 32'(fwd_sel_1), 32'h0);
        mem_rd_addr = 5'd9; ext_hold = 1'b1;
        #1 check_eq("fwd_under_hold", 32'(fwd_sel_3), 32'h8);
        clear_inputs();
        tick();

        // LOAD_LAT=1 vs LOAD_LAT=3 with a single-cycle hazard
        set_hazard();
        #1 check_eq("hz_c0_stall1", 32'(stall_1), 32'h1);
        check_eq("hz_c0_bubble1", 32'(bubble_1), 32'h1);
        check_eq("hz_c0_stall3", 32'(stall_3), 32'h1);
        tick();
        clear_hazard();
        #1 check_eq("hz_c1_stall1", 32'(stall_1), 32'h0);
        check_eq("hz_c1_stall3", 32'(stall_3), 32'h1);
        tick();
        check_eq("hz_c2_stall3", 32'(stall_3), 32'h1);
        tick();
        check_eq("hz_c3_stall3", 32'(stall_3), 32'h0);

        // no hazard variants
        set_hazard(); id_rs_used = 2'b00;
        #1 check_eq("nohz_unused", 32'(stall_1), 32'h0);
        id_rs_used = 2'b11; id_rs_addr = {5'd0, 5'd0}; ex_rd_addr = 5'd0;
        #1 check_eq("nohz_x0", 32'(stall_3), 32'h0);
        set_hazard(); ex_reg_write = 1'b0;
        #1 check_eq("nohz_nowrite", 32'(stall_1), 32'h0);
        clear_hazard();
        tick();

        // LOAD_LAT=3 with ext_hold for 2 STALL cycles; hazard left asserted into STALL
        run_len = 0;
        for (int c = 0; c < 10; c++) begin
            if (c <= 3) set_hazard(); else clear_hazard();
            ext_hold = (c == 1 || c == 2);
            #1;
            if (stall_3) begin
                if (run_len == c) run_len++;
            end
            tick();
        end
        ext_hold = 1'b0;
        check_eq("hold_run_len", 32'(run_len), 32'd5);
        check_eq("hold_end_idle", 32'(stall_3), 32'h0);

        // ext_hold in IDLE with hz: outputs assert, transition deferred
        set_hazard(); ext_hold = 1'b1;
        #1 check_eq("idle_hold_stall", 32'(stall_3), 32'h1);
        tick();
        tick();
        clear_hazard(); ext_hold = 1'b0;
        #1 check_eq("idle_hold_deferred", 32'(stall_3), 32'h0);
        tick();

        // reset in the 2nd STALL cycle
        set_hazard();
        tick();
        clear_hazard();
        tick();
        check_eq("pre_rst_stall3", 32'(stall_3), 32'h1);
        arst_n = 1'b0;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd4; ex_rs_addr = {5'd4, 5'd4};
        #1 check_eq("rst_mid_stall", 32'(stall_3), 32'h0);
        check_eq("rst_mid_bubble", 32'(bubble_3), 32'h0);
        check_eq("rst_mid_fwd", 32'(fwd_sel_3), 32'h0);
        tick();
        arst_n = 1'b1;
        clear_inputs();
        #1 check_eq("post_rst_idle", 32'(stall_3), 32'h0);
        tick();
        check_eq("post_rst_idle2", 32'(stall_3), 32'h0);

`ifdef FWD_PERF_EN
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        check_eq("perf_rst", pf_2, 32'd0);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd6; ex_rs_addr = {5'd0, 5'd6};
        for (int c = 0; c < 4; c++) tick();
        clear_inputs();
        ext_hold = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = 5'd6; ex_rs_addr = {5'd0, 5'd6};
        tick();
        clear_inputs();
        set_hazard();
        tick();
        clear_hazard();
        tick();
        tick();
        check_eq("perf_fwd_4", pf_2, 32'd4);
        check_eq("perf_stall_2", ps_2, 32'd2);
        check_eq("perf_fwd_sat", 32'(pf_1), 32'd3);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd6; ex_rs_addr = {5'd0, 5'd6};
        tick();
        tick();
        clear_inputs();
        check_eq("perf_fwd_sat_hold", 32'(pf_1), 32'd3);
        check_eq("perf_stall_1", 32'(ps_1), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the RV pipeline.
- Generates per-source operand bypass selects for the EX stage: EX/MEM, MEM/WB or register file.
- Detects load-use hazards between the ID/EX load and the IF/ID consumer, then runs a stall FSM that holds PC/IF-ID and injects bubbles into ID/EX for a parametrised number of cycles.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, optional rs3).
- LOAD_LAT, 1, bubble cycles needed between a load and its consumer; must be 1..7.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- id_rs_addr  in  NUM_SRC*REG_ADDR_W  source addresses of the IF/ID instruction; src i at [i*REG_ADDR_W +: REG_ADDR_W].
- id_rs_used  in  NUM_SRC  per-source valid for the IF/ID instruction.
- ex_rs_addr  in  NUM_SRC*REG_ADDR_W  source addresses of the ID/EX instruction.
- ex_rd_addr  in  REG_ADDR_W  rd in ID/EX.
- ex_reg_write  in  1  ID/EX writes rd.
- ex_mem_read  in  1  ID/EX instruction is a load.
- mem_rd_addr  in  REG_ADDR_W  rd in EX/MEM.
- mem_reg_write  in  1  EX/MEM writes rd.
- wb_rd_addr  in  REG_ADDR_W  rd in MEM/WB.
- wb_reg_write  in  1  MEM/WB writes rd.
- ext_hold  in  1  global pipeline freeze, e.g. a memory wait.
- fwd_sel  out  NUM_SRC*2  per-source select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control signals.

Behaviour:
- Reset: while arst_n==0 at a clk edge, state<=IDLE and cnt<=0. While arst_n is low, fwd_sel=0, stall=0 and bubble=0.
- Forwarding (combinational, zero latency), for each src i:
  - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs[i].
  - else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs[i].
  - else 00.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
  - Every bit of fwd_sel is always driven, with no latch inference.
- Hazard: hz = ex_mem_read && ex_reg_write && ex_rd!=0 && OR over i of (id_rs_used[i] && id_rs[i]==ex_rd).
- FSM states: IDLE, STALL.
  - IDLE, hz=1: stall=1 and bubble=1 in the same cycle (Mealy). If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; else stay IDLE.
  - STALL: stall=1, bubble=1. If !ext_hold, cnt decrements. When cnt==1 and !ext_hold, go to IDLE next cycle.
  - hz is ignored in STALL because the bubbled load has already advanced.
- ext_hold=1:
  - FSM state and cnt freeze.
  - stall and bubble keep their current values. In IDLE with hz=1 the outputs assert, but the transition is deferred.
  - fwd_sel is unaffected.
- Reset mid-stall: the FSM aborts to IDLE and outputs deassert the same cycle arst_n is sampled low.
- Widths: all compares are full REG_ADDR_W. cnt is 3 bits.

Optional Feature:
- Macro: FWD_PERF_EN.
- Defined:
  - Adds outputs perf_fwd_cnt and perf_stall_cnt, each CNT_W wide and reset to 0.
  - perf_fwd_cnt increments once per cycle in which any fwd_sel!=00 and !ext_hold.
  - perf_stall_cnt increments on every cycle with stall=1.
  - Both counters saturate at all-ones.
- Undefined: ports and logic are absent, and the module is functionally identical otherwise.

Decomposition:
- Package fwd_pkg holds:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding ST_IDLE=1'b0, ST_STALL=1'b1.
- One sub-module, fwd_src_sel: a single-source priority select. It takes ex_rs, mem/wb rd and write enables, returns a 2-bit sel, and is instantiated NUM_SRC times via generate.

Test Plan:
- mem_reg_write=1, mem_rd=5, ex_rs0=5, wb_reg_write=1, wb_rd=5 -> fwd_sel[1:0]=10 (EX/MEM priority); with mem_reg_write=0 -> 01.
- mem_rd=0, mem_reg_write=1, ex_rs0=0 -> fwd_sel=00 (x0 never forwarded).
- LOAD_LAT=1: ex_mem_read=1, ex_rd=7, id_rs1=7, id_rs_used=2'b10 -> stall=bubble=1 for exactly 1 cycle; with id_rs_used=0 -> no stall.
- LOAD_LAT=3, same hazard, ext_hold pulsed for 2 cycles during STALL -> stall high for 5 consecutive cycles, then IDLE.
- arst_n low in the 2nd STALL cycle -> next cycle state=IDLE, stall=bubble=0; fwd_sel=00 while arst_n is low.
- FWD_PERF_EN: 4 forward cycles plus 1 hazard with LOAD_LAT=2 -> perf_fwd_cnt=4, perf_stall_cnt=2. Preload perf_fwd_cnt to all-ones -> stays all-ones.
